// File: rtl/wb_regfile.sv
// Register file with write-back commit, same-cycle read bypass, a busy
// scoreboard for decode hazard detection, branch redirect and a retire counter.
module wb_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_i,
  input  logic [3:0]        rd_addr_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              branch_en_i,
  input  logic [3:0]        rs0_addr_i,
  input  logic [3:0]        rs1_addr_i,
  output logic [DATA_W-1:0] rs0_value_o,
  output logic [DATA_W-1:0] rs1_value_o,
  input  logic              issue_i,
  input  logic              issue_wb_i,
  input  logic [3:0]        issue_addr_i,
  output logic              hazard_o,
  output logic              pc_load_o,
  output logic [15:0]       pc_target_o,
  output logic [31:0]       retired_o
);

  logic [DATA_W-1:0] regs [16];
  logic [15:0]       busy_q;
  logic [15:0]       busy_nxt;
  logic [31:0]       retired_q;
  logic              pc_load_p1;
  logic [15:0]       pc_target_p1;
  logic              commit;
  logic              byp0;
  logic              byp1;

  // A taken branch squashes the write-back of the result it carries.
  assign commit = wb_en_i & ~branch_en_i;
  assign byp0   = commit & (rs0_addr_i == rd_addr_i);
  assign byp1   = commit & (rs1_addr_i == rd_addr_i);

  // Combinational reads, forwarding the committing result on an address match.
  always_comb begin
    rs0_value_o = regs[rs0_addr_i];
    rs1_value_o = regs[rs1_addr_i];
    if (byp0) rs0_value_o = result_i;
    if (byp1) rs1_value_o = result_i;
  end

  // An operand is a hazard only if it is busy and not being bypassed right now.
  always_comb begin
    hazard_o = (busy_q[rs0_addr_i] & ~byp0) | (busy_q[rs1_addr_i] & ~byp1);
  end

  // Scoreboard update: clear on commit, then set on issue (newer wins), flush overrides all.
  always_comb begin
    busy_nxt = busy_q;
    if (commit) busy_nxt[rd_addr_i] = 1'b0;
    if (issue_i && issue_wb_i) busy_nxt[issue_addr_i] = 1'b1;
    if (branch_en_i) busy_nxt = '0;
  end

  // Register array write on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[rd_addr_i] <= result_i;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_nxt;
  end

  // Retire counter, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        retired_q <= '0;
    else if (commit) retired_q <= retired_q + 32'd1;
  end

  // Stage p1: branch redirect, one-cycle load pulse with a held target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_load_p1   <= 1'b0;
      pc_target_p1 <= '0;
    end else begin
      pc_load_p1 <= branch_en_i;
      if (branch_en_i) pc_target_p1 <= result_i[15:0];
    end
  end

  assign pc_load_o   = pc_load_p1;
  assign pc_target_o = pc_target_p1;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: write/read, bypass, scoreboard, branch flush,
// retire-counter wrap and asynchronous reset.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_en_i;
  logic [3:0]  rd_addr_i;
  logic [31:0] result_i;
  logic        branch_en_i;
  logic [3:0]  rs0_addr_i;
  logic [3:0]  rs1_addr_i;
  logic [31:0] rs0_value_o;
  logic [31:0] rs1_value_o;
  logic        issue_i;
  logic        issue_wb_i;
  logic [3:0]  issue_addr_i;
  logic        hazard_o;
  logic        pc_load_o;
  logic [15:0] pc_target_o;
  logic [31:0] retired_o;

  int checks = 0;
  int fails  = 0;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_i      (wb_en_i),
    .rd_addr_i    (rd_addr_i),
    .result_i     (result_i),
    .branch_en_i  (branch_en_i),
    .rs0_addr_i   (rs0_addr_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs0_value_o  (rs0_value_o),
    .rs1_value_o  (rs1_value_o),
    .issue_i      (issue_i),
    .issue_wb_i   (issue_wb_i),
    .issue_addr_i (issue_addr_i),
    .hazard_o     (hazard_o),
    .pc_load_o    (pc_load_o),
    .pc_target_o  (pc_target_o),
    .retired_o    (retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en_i = 0; branch_en_i = 0; issue_i = 0; issue_wb_i = 0;
  endtask

  initial begin
    rst = 0;
    idle();
    rd_addr_i = 0; result_i = 0; rs0_addr_i = 0; rs1_addr_i = 0; issue_addr_i = 0;
    #1;
    chk("reset_rs0", rs0_value_o, 32'h0);
    chk("reset_hazard", {31'b0, hazard_o}, 32'h0);
    chk("reset_pc_load", {31'b0, pc_load_o}, 32'h0);
    chk("reset_pc_target", {16'b0, pc_target_o}, 32'h0);
    chk("reset_retired", retired_o, 32'h0);
    tick();
    #2 rst = 1;
    tick();

    // Write then read r5
    wb_en_i = 1; rd_addr_i = 5; result_i = 32'hDEADBEEF;
    tick();
    idle(); rs0_addr_i = 5; rs1_addr_i = 0;
    #1;
    chk("wr_rd_r5", rs0_value_o, 32'hDEADBEEF);
    chk("wr_rd_retired", retired_o, 32'd1);
    chk("wr_rd_r0_untouched", rs1_value_o, 32'h0);

    // r0 is an ordinary register
    wb_en_i = 1; rd_addr_i = 0; result_i = 32'h11111111;
    tick();
    idle(); #1;
    chk("r0_write", rs1_value_o, 32'h11111111);
    chk("r0_retired", retired_o, 32'd2);

    // Bypass: r3 busy, then committed while being read
    issue_i = 1; issue_wb_i = 1; issue_addr_i = 3;
    tick();
    idle(); rs1_addr_i = 3; #1;
    chk("byp_hazard_before", {31'b0, hazard_o}, 32'h1);
    wb_en_i = 1; rd_addr_i = 3; result_i = 32'h12345678; #1;
    chk("byp_rs1_value", rs1_value_o, 32'h12345678);
    chk("byp_hazard_zero", {31'b0, hazard_o}, 32'h0);
    chk("byp_rs0_other", rs0_value_o, 32'hDEADBEEF);
    tick();
    idle(); #1;
    chk("byp_rs1_stored", rs1_value_o, 32'h12345678);
    chk("byp_hazard_after", {31'b0, hazard_o}, 32'h0);
    chk("byp_retired", retired_o, 32'd3);

    // Scoreboard on r7
    issue_i = 1; issue_wb_i = 1; issue_addr_i = 7;
    tick();
    idle(); rs0_addr_i = 7; rs1_addr_i = 0; #1;
    chk("sb_hazard_set", {31'b0, hazard_o}, 32'h1);
    wb_en_i = 1; rd_addr_i = 7; result_i = 32'h77;
    tick();
    idle(); #1;
    chk("sb_hazard_clear", {31'b0, hazard_o}, 32'h0);
    chk("sb_r7", rs0_value_o, 32'h77);
    chk("sb_retired", retired_o, 32'd4);
    // Issue without write-back flag does not mark busy
    issue_i = 1; issue_wb_i = 0; issue_addr_i = 7;
    tick();
    idle(); #1;
    chk("sb_issue_nowb", {31'b0, hazard_o}, 32'h0);
    // Same-edge issue and commit to r7: busy stays set
    issue_i = 1; issue_wb_i = 1; issue_addr_i = 7;
    wb_en_i = 1; rd_addr_i = 7; result_i = 32'h78;
    tick();
    idle(); #1;
    chk("sb_same_edge_hazard", {31'b0, hazard_o}, 32'h1);
    chk("sb_same_edge_r7", rs0_value_o, 32'h78);
    chk("sb_same_edge_retired", retired_o, 32'd5);
    wb_en_i = 1; rd_addr_i = 7; result_i = 32'h79;
    tick();
    idle(); #1;
    chk("sb_final_clear", {31'b0, hazard_o}, 32'h0);
    chk("sb_final_retired", retired_o, 32'd6);

    // Branch: busy = 0x00F0, branch with wb_en and a same-edge issue
    for (int a = 4; a < 8; a++) begin
      issue_i = 1; issue_wb_i = 1; issue_addr_i = 4'(a);
      tick();
    end
    idle(); rs0_addr_i = 4; rs1_addr_i = 2; #1;
    chk("br_hazard_before", {31'b0, hazard_o}, 32'h1);
    branch_en_i = 1; wb_en_i = 1; rd_addr_i = 2; result_i = 32'h0000ABCD;
    issue_i = 1; issue_wb_i = 1; issue_addr_i = 9; #1;
    chk("br_no_bypass", rs1_value_o, 32'h0);
    chk("br_pc_load_pre", {31'b0, pc_load_o}, 32'h0);
    tick();
    idle(); #1;
    chk("br_pc_load", {31'b0, pc_load_o}, 32'h1);
    chk("br_pc_target", {16'b0, pc_target_o}, 32'h0000ABCD);
    chk("br_no_write", rs1_value_o, 32'h0);
    chk("br_retired", retired_o, 32'd6);
    chk("br_flush_r4", {31'b0, hazard_o}, 32'h0);
    rs0_addr_i = 9; rs1_addr_i = 7; #1;
    chk("br_flush_issue", {31'b0, hazard_o}, 32'h0);
    tick();
    chk("br_pc_load_pulse", {31'b0, pc_load_o}, 32'h0);
    chk("br_pc_target_hold", {16'b0, pc_target_o}, 32'h0000ABCD);

    // Retire counter wrap
    dut.retired_q = 32'hFFFF_FFFF;
    wb_en_i = 1; rd_addr_i = 1; result_i = 32'h1;
    tick();
    idle(); #1;
    chk("wrap_retired", retired_o, 32'h0);

    // Asynchronous reset mid-sequence, with a busy bit and a pending write
    issue_i = 1; issue_wb_i = 1; issue_addr_i = 5;
    tick();
    idle(); rs0_addr_i = 5; #1;
    chk("ar_hazard_pre", {31'b0, hazard_o}, 32'h1);
    wb_en_i = 1; rd_addr_i = 6; result_i = 32'hCAFEF00D;
    branch_en_i = 0;
    #2 rst = 0;
    #1;
    chk("ar_rs0", rs0_value_o, 32'h0);
    chk("ar_hazard", {31'b0, hazard_o}, 32'h0);
    chk("ar_retired", retired_o, 32'h0);
    chk("ar_pc_target", {16'b0, pc_target_o}, 32'h0);
    chk("ar_pc_load", {31'b0, pc_load_o}, 32'h0);
    tick();
    idle();
    #2 rst = 1;
    tick();
    for (int r = 0; r < 16; r++) begin
      rs0_addr_i = 4'(r); #1;
      chk($sformatf("ar_read_r%0d", r), rs0_value_o, 32'h0);
    end
    chk("ar_retired_after", retired_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
